md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div and divu into the HI/LO registers, and executes mthi and mtlo.
- Serves mfhi and mflo reads through E_MDU_OUT.
- It is the responder to the hazard/stall controller: it exports busy, and the controller stalls any D-stage HI/LO instruction while E_MDU_START or busy is high.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- E_MDU_OP  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
- E_MDU_START  input  1  high for exactly one cycle when the E-stage instruction is mult/multu/div/divu
- E_A  input  32  rs operand, post-forwarding
- E_B  input  32  rt operand, post-forwarding
- E_MDU_SEL  input  1  read select for E_MDU_OUT: 0 = LO, 1 = HI
- E_MDU_OUT  output  32  combinational: E_MDU_SEL ? hi : lo
- busy  output  1  registered; high while an operation is in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, cnt=0, pending results=0, state=IDLE.
  - Reset asserted mid-operation aborts it: no HI/LO update occurs after release.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; cnt counts down to 1.
- Start condition: IDLE, E_MDU_START=1 and E_MDU_OP in {001..100} at edge t. On that edge:
  - Compute and latch the 64-bit pending result {ph, pl}.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- busy timing:
  - busy=1 in cycles t+1 .. t+K, where K = the loaded count.
  - In the cycle where RUN and cnt=1, the next edge writes hi=ph, lo=pl, sets busy=0 and returns to IDLE.
  - New values are visible from cycle t+K+1.
- Arithmetic:
  - mult: {ph,pl} = signed(E_A) * signed(E_B), full 64 bits.
  - multu: same, unsigned.
  - div: pl = quotient truncated toward zero; ph = remainder, which carries the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div with 0x80000000 / 0xFFFFFFFF: pl=0x80000000, ph=0.
  - Divide by zero (E_B=0): the unit still goes busy for DIV_CYCLES, but the final write is suppressed, so hi/lo keep their previous values.
- mthi/mtlo:
  - Only in IDLE, with E_MDU_START=0.
  - Single cycle: the next edge writes hi=E_A (mthi) or lo=E_A (mtlo). No busy.
- Ignored inputs:
  - mthi/mtlo while busy=1: ignored. The stall controller prevents this; the bench asserts it never happens.
  - E_MDU_START while busy=1: ignored, and the in-flight operation continues unaffected. The bench flags this as a protocol violation.
  - E_MDU_START=1 with OP not in {001..100}: ignored.
  - OP 001..100 with E_MDU_START=0: no effect.
- Reads:
  - E_MDU_OUT always reflects the current hi/lo registers.
  - A read during RUN returns the old values; the stall controller guarantees mfhi/mflo never reach E while busy.
- Simultaneous events:
  - In the completion cycle (busy=1, cnt=1), any start/mthi/mtlo presented that cycle is ignored. The controller stalls them because busy=1.
  - The first acceptable start is in the cycle busy reads 0.
- busy is a pure register output with no combinational path from inputs. The controller must OR it with E_MDU_START for hazard detection.

Test Plan:
1. Reset, then mult with E_A=0xFFFFFFFE (−2), E_B=3:
   - busy high for cycles 1..5.
   - From cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
2. multu with E_A=0xFFFFFFFF, E_B=0xFFFFFFFF:
   - After 5 busy cycles: hi=0xFFFFFFFE, lo=0x00000001.
3. div and divu, checked after 10 busy cycles each:
   - div −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - divu 7/2: lo=3, hi=1.
   - div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
4. Divide by zero with prior hi=0x11, lo=0x22:
   - busy held for 10 cycles.
   - hi=0x11, lo=0x22 unchanged.
5. mthi/mtlo:
   - mthi E_A=0xDEADBEEF, then mtlo E_A=0x12345678 in consecutive IDLE cycles: next cycles hi=0xDEADBEEF, lo=0x12345678, busy never asserts.
   - Then E_MDU_SEL=1 gives E_MDU_OUT=0xDEADBEEF; E_MDU_SEL=0 gives 0x12345678.
6. Abort and ignore:
   - Start mult 3*4 and assert reset low at busy cycle 2: hi=lo=0 immediately, busy=0, and no later update after release.
   - Separately, E_MDU_START pulse during busy is ignored, and the original result still lands at cycle t+K+1.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO, exports busy to the hazard controller.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDU_OP,
    input  logic        E_MDU_START,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_MDU_SEL,
    output logic [31:0] E_MDU_OUT,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ph_q, ph_d;
    logic [31:0] pl_q, pl_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dvs_s, dvs_u;
    logic [31:0] qa, ra, q_s, r_s, q_u, r_u;
    logic        is_md;

    // Full-width products for signed and unsigned multiply
    assign prod_s = $signed({{32{E_A[31]}}, E_A})
                  * $signed({{32{E_B[31]}}, E_B});
    assign prod_u = {32'b0, E_A} * {32'b0, E_B};

    // Signed divide via magnitudes so that truncation toward zero and
    // the 0x80000000 / -1 overflow case come out well defined.
    // A zero divisor is replaced by 1; that result is discarded anyway.
    assign abs_a = E_A[31] ? -E_A : E_A;
    assign abs_b = E_B[31] ? -E_B : E_B;
    assign dvs_s = (E_B == 32'd0) ? 32'd1 : abs_b;
    assign dvs_u = (E_B == 32'd0) ? 32'd1 : E_B;
    assign qa    = abs_a / dvs_s;
    assign ra    = abs_a % dvs_s;
    assign q_s   = (E_A[31] ^ E_B[31]) ? -qa : qa;
    assign r_s   = E_A[31] ? -ra : ra;
    assign q_u   = E_A / dvs_u;
    assign r_u   = E_A % dvs_u;

    assign is_md = (E_MDU_OP >= OP_MULT) && (E_MDU_OP <= OP_DIVU);

    // State, countdown, pending result and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ph_q    <= 32'd0;
            pl_q    <= 32'd0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: accept starts and moves in IDLE, count down in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (E_MDU_START && is_md) begin
                    state_d = RUN;
                    dz_d    = 1'b0;
                    unique case (E_MDU_OP)
                        OP_MULT: begin
                            {ph_d, pl_d} = prod_s;
                            cnt_d        = 4'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {ph_d, pl_d} = prod_u;
                            cnt_d        = 4'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            ph_d  = r_s;
                            pl_d  = q_s;
                            cnt_d = 4'(DIV_CYCLES);
                            dz_d  = (E_B == 32'd0);
                        end
                        default: begin
                            ph_d  = r_u;
                            pl_d  = q_u;
                            cnt_d = 4'(DIV_CYCLES);
                            dz_d  = (E_B == 32'd0);
                        end
                    endcase
                end else if (!E_MDU_START && E_MDU_OP == OP_MTHI) begin
                    hi_d = E_A;
                end else if (!E_MDU_START && E_MDU_OP == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (!dz_q) begin
                        hi_d = ph_q;
                        lo_d = pl_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign E_MDU_OUT = E_MDU_SEL ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit.
// Checks timing of busy and HI/LO results against hand values.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  E_MDU_OP = 3'd0;
    logic        E_MDU_START = 1'b0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        E_MDU_SEL = 1'b0;
    logic [31:0] E_MDU_OUT;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nvec = 0;
    int nerr = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .E_MDU_OP(E_MDU_OP),
        .E_MDU_START(E_MDU_START),
        .E_A(E_A),
        .E_B(E_B),
        .E_MDU_SEL(E_MDU_SEL),
        .E_MDU_OUT(E_MDU_OUT),
        .busy(busy),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    // mthi/mtlo must never be presented while busy
    always @(negedge clk) begin
        if (reset && busy && !E_MDU_START
            && (E_MDU_OP == 3'd5 || E_MDU_OP == 3'd6))
            $error("mthi/mtlo presented while busy");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div op, check busy window, then the results
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int k, input logic [31:0] old_hi,
                          input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        E_MDU_OP    = op;
        E_A         = a;
        E_B         = b;
        E_MDU_START = 1'b1;
        tick();
        E_MDU_START = 1'b0;
        E_MDU_OP    = 3'd0;
        chk({tag, "_oldhi"}, hi, old_hi);
        for (int i = 1; i <= k; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            tick();
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,
               32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10,
               32'hFFFF_FFFF, 32'd1, 32'd3);
        run_op("divov", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'd1, 32'd0, 32'h8000_0000);

        // Divide by zero keeps the previous HI/LO
        E_MDU_OP = 3'd5; E_A = 32'h11;
        tick();
        E_MDU_OP = 3'd6; E_A = 32'h22;
        tick();
        E_MDU_OP = 3'd0;
        run_op("divz", 3'd3, 32'd99, 32'd0, 10,
               32'h11, 32'h11, 32'h22);

        // Move-to HI/LO in consecutive idle cycles
        E_MDU_OP = 3'd5; E_A = 32'hDEAD_BEEF;
        tick();
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        E_MDU_OP = 3'd6; E_A = 32'h1234_5678;
        tick();
        E_MDU_OP = 3'd0;
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        E_MDU_SEL = 1'b1;
        #1;
        chk("out_hi", E_MDU_OUT, 32'hDEAD_BEEF);
        E_MDU_SEL = 1'b0;
        #1;
        chk("out_lo", E_MDU_OUT, 32'h1234_5678);

        // Reserved op with start, and md op without start: no effect
        E_MDU_OP = 3'd7; E_MDU_START = 1'b1; E_A = 32'd5;
        tick();
        chk("rsv_busy", {31'd0, busy}, 32'd0);
        E_MDU_OP = 3'd1; E_MDU_START = 1'b0;
        tick();
        E_MDU_OP = 3'd0;
        chk("nostart_busy", {31'd0, busy}, 32'd0);
        chk("nostart_hi", hi, 32'hDEAD_BEEF);
        chk("nostart_lo", lo, 32'h1234_5678);

        // Reset during busy aborts the operation
        E_MDU_OP = 3'd1; E_A = 32'd3; E_B = 32'd4; E_MDU_START = 1'b1;
        tick();
        E_MDU_START = 1'b0; E_MDU_OP = 3'd0;
        tick();
        chk("abort_busy2", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        // Start pulse during busy is ignored
        E_MDU_OP = 3'd1; E_A = 32'd6; E_B = 32'd7; E_MDU_START = 1'b1;
        tick();
        E_MDU_START = 1'b0; E_MDU_OP = 3'd0;
        tick();
        $display("note: start pulse during busy (protocol violation)");
        E_MDU_OP = 3'd3; E_A = 32'd100; E_B = 32'd3; E_MDU_START = 1'b1;
        tick();
        E_MDU_START = 1'b0; E_MDU_OP = 3'd0;
        chk("ign_busy3", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy4", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy5", {31'd0, busy}, 32'd1);
        chk("ign_old_lo", lo, 32'd0);
        tick();
        chk("ign_done", {31'd0, busy}, 32'd0);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);
        tick();
        chk("ign_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
